// File: rtl/stopwatch_display_scan.sv
// Six-digit multiplexed seven-segment scanner for a three-stage stopwatch.
// Snapshots are taken once per frame so that a frame never mixes old and new counts.
module stopwatch_display_scan #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] q0,
  input  logic [6:0] q1,
  input  logic [6:0] q2,
  input  logic       overflow2,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  dig_idx_q, dig_idx_d;
  logic [6:0]  s0_q, s1_q, s2_q;
  logic        ovf_q;
  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [6:0]  cur_val;
  logic        div_wrap, frame_end;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Out-of-range values show a dash on both digits; that takes priority over blanking.
  function automatic logic [6:0] digit_seg(input logic [6:0] v, input logic tens,
                                           input logic blank_zero);
    logic [3:0] t, o;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    if (v >= 7'd100) return SEG_DASH;
    if (!tens)       return seg_lut(o);
    if (blank_zero && t == 4'd0) return SEG_BLANK;
    return seg_lut(t);
  endfunction

  assign div_wrap  = (div_cnt_q == DIV_LAST);
  assign frame_end = div_wrap && (dig_idx_q == 3'd5);

  always_comb begin
    div_cnt_d = div_wrap ? 16'd0 : div_cnt_q + 16'd1;
    dig_idx_d = dig_idx_q;
    if (div_wrap) dig_idx_d = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;

    case (dig_idx_q[2:1])
      2'd0:    cur_val = s0_q;
      2'd1:    cur_val = s1_q;
      default: cur_val = s2_q;
    endcase

    an_d  = ~(6'b000001 << dig_idx_q);
    seg_d = digit_seg(cur_val, dig_idx_q[0], BLANK_LZ && (dig_idx_q == 3'd5));
    dp_d  = ~(ovf_q && (dig_idx_q == 3'd5));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= 16'd0;
      dig_idx_q <= 3'd0;
      s0_q      <= 7'd0;
      s1_q      <= 7'd0;
      s2_q      <= 7'd0;
      ovf_q     <= 1'b0;
      an_q      <= 6'b111111;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      // Outputs use the pre-load snapshot, so digit 5 of the old frame stays consistent.
      if (frame_end) begin
        s0_q <= q0;
        s1_q <= q1;
        s2_q <= q2;
      end
      ovf_q <= ovf_q | overflow2;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Bench for stopwatch_display_scan: three instances (SCAN_DIV 2, 1 and 3 with blanking)
// compared each cycle against a frame/edge-count reference model.
module tb_stopwatch_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] q0, q1, q2;
  logic       overflow2;
  logic [5:0] an_w  [3];
  logic [6:0] seg_w [3];
  logic       dp_w  [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stopwatch_display_scan #(.SCAN_DIV(2), .BLANK_LZ(1'b0)) dut_d2 (
    .clk(clk), .reset(reset), .q0(q0), .q1(q1), .q2(q2), .overflow2(overflow2),
    .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0]));
  stopwatch_display_scan #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_d1 (
    .clk(clk), .reset(reset), .q0(q0), .q1(q1), .q2(q2), .overflow2(overflow2),
    .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1]));
  stopwatch_display_scan #(.SCAN_DIV(3), .BLANK_LZ(1'b1)) dut_d3 (
    .clk(clk), .reset(reset), .q0(q0), .q1(q1), .q2(q2), .overflow2(overflow2),
    .an(an_w[2]), .seg(seg_w[2]), .dp(dp_w[2]));

  function automatic int div_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic logic [6:0] digit_code(int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  function automatic logic [6:0] ref_seg(int dig, logic [6:0] a, logic [6:0] b,
                                         logic [6:0] c, bit blank);
    int v;
    v = (dig < 2) ? int'(a) : ((dig < 4) ? int'(b) : int'(c));
    if (v >= 100) return 7'b0111111;
    if (dig % 2 == 0) return digit_code(v % 10);
    if (blank && dig == 5 && v / 10 == 0) return 7'b1111111;
    return digit_code(v / 10);
  endfunction

  // Reference: edge k after reset release shows digit ((k-1)/D)%6; the snapshot
  // is refreshed on every edge that ends a frame (k a multiple of 6*D).
  int         mk [3];
  logic [6:0] ms0 [3], ms1 [3], ms2 [3];
  logic       movf [3];
  logic [5:0] e_an [3];
  logic [6:0] e_seg [3];
  logic       e_dp [3];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mk[i]    <= 0;
        ms0[i]   <= 7'd0;
        ms1[i]   <= 7'd0;
        ms2[i]   <= 7'd0;
        movf[i]  <= 1'b0;
        e_an[i]  <= 6'b111111;
        e_seg[i] <= 7'b1111111;
        e_dp[i]  <= 1'b1;
      end else begin
        mk[i]    <= mk[i] + 1;
        e_an[i]  <= ~(6'd1 << ((mk[i] / div_of(i)) % 6));
        e_seg[i] <= ref_seg((mk[i] / div_of(i)) % 6, ms0[i], ms1[i], ms2[i], i == 2);
        e_dp[i]  <= !(movf[i] && ((mk[i] / div_of(i)) % 6 == 5));
        movf[i]  <= movf[i] | overflow2;
        if ((mk[i] + 1) % (6 * div_of(i)) == 0) begin
          ms0[i] <= q0;
          ms1[i] <= q1;
          ms2[i] <= q2;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("an[%0d]", i), 32'(an_w[i]), 32'(e_an[i]));
      chk($sformatf("seg[%0d]", i), 32'(seg_w[i]), 32'(e_seg[i]));
      chk($sformatf("dp[%0d]", i), 32'(dp_w[i]), 32'(e_dp[i]));
      if (!reset) chk($sformatf("onehot[%0d]", i), 32'($countones(~an_w[i])), 32'd1);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_an[%0d]", tag, i), 32'(an_w[i]), 32'h3f);
      chk($sformatf("%s_seg[%0d]", tag, i), 32'(seg_w[i]), 32'h7f);
      chk($sformatf("%s_dp[%0d]", tag, i), 32'(dp_w[i]), 32'h1);
    end
  endtask

  function automatic logic [6:0] rq();
    return ($urandom % 4 == 0) ? 7'($urandom_range(127, 100)) : 7'($urandom_range(99, 0));
  endfunction

  task automatic random_run(int n, bit small_q2);
    for (int c = 0; c < n; c++) begin
      if ($urandom % 3 == 0) begin
        case ($urandom % 3)
          0:       q0 = rq();
          1:       q1 = rq();
          default: q2 = (small_q2 && $urandom % 2 == 0) ? 7'($urandom_range(9, 0)) : rq();
        endcase
      end
      step();
    end
  endtask

  logic [5:0] f2_an  [6];
  logic [6:0] f2_seg [6];

  initial begin
    reset = 1'b1;
    q0 = 7'd0; q1 = 7'd0; q2 = 7'd0;
    overflow2 = 1'b0;
    f2_an  = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
    f2_seg = '{7'b0100100, 7'b0011001, 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000};
    #12;
    chk_reset_outs("por");

    // Directed decode: 42/7/0 held over two frames; overflow high during reset is ignored.
    q0 = 7'd42; q1 = 7'd7; q2 = 7'd0;
    overflow2 = 1'b1;
    @(negedge clk);
    overflow2 = 1'b0;
    reset = 1'b0;
    step();
    chk("first_an", 32'(an_w[0]), 32'h3e);
    chk("first_seg", 32'(seg_w[0]), 32'h40);
    chk("first_dp", 32'(dp_w[0]), 32'h1);
    for (int c = 0; c < 11; c++) step();
    for (int j = 0; j < 6; j++) begin
      step();
      chk($sformatf("frame2_an%0d", j), 32'(an_w[0]), 32'(f2_an[j]));
      chk($sformatf("frame2_seg%0d", j), 32'(seg_w[0]), 32'(f2_seg[j]));
      step();
    end

    // Anti-tearing with values changing mid-frame, including out-of-range.
    q0 = 7'd59;
    q1 = 7'd100;
    random_run(200, 1'b0);

    // One-cycle overflow pulse, then it must stick.
    overflow2 = 1'b1;
    step();
    overflow2 = 1'b0;
    random_run(150, 1'b0);

    // Asynchronous reset between edges, mid-frame.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outs("async");
    step();
    step();
    reset = 1'b0;

    // Leading-zero blanking on the BLANK_LZ instance.
    q2 = 7'd5;
    random_run(40, 1'b0);
    random_run(150, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
